// File: rtl/led_pio_pkg.sv
// rtl/led_pio_pkg.sv - register map constants shared by the LED output PIO
package led_pio_pkg;

    // Word addresses of the Avalon-MM register map; address 7 is unmapped.
    localparam logic [2:0] ADDR_DATA         = 3'd0;
    localparam logic [2:0] ADDR_SET          = 3'd1;
    localparam logic [2:0] ADDR_CLEAR        = 3'd2;
    localparam logic [2:0] ADDR_TOGGLE       = 3'd3;
    localparam logic [2:0] ADDR_BLINK_MASK   = 3'd4;
    localparam logic [2:0] ADDR_BLINK_PERIOD = 3'd5;
    localparam logic [2:0] ADDR_STATUS       = 3'd6;

    // Bit of the STATUS word that reports the blink phase.
    localparam int unsigned STATUS_PHASE_BIT = 0;

endpackage

// File: rtl/led_pio_out_if.sv
// rtl/led_pio_out_if.sv - Avalon-MM slave bus bundle for the LED output PIO
//
// address    : word address of the register
// chipselect : slave select, qualifies write_n
// write_n    : active-low write strobe
// writedata  : write data
// readdata   : combinational read data, zero wait states
interface led_pio_out_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/led_pio_blink_prescaler.sv
// rtl/led_pio_blink_prescaler.sv - down-counter that generates the LED blink phase
//
// clk        : system clock
// reset_n    : asynchronous active-low reset
// load       : restart the engine from load_value with phase forced on
// load_value : blink period; the new value while load is high, the stored one otherwise
// phase      : 1 = ON half, 0 = OFF half; held at 1 while the period is 0
// cnt        : current down-counter value
module led_pio_blink_prescaler #(
    parameter int unsigned PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [PRESCALE_W-1:0] load_value,
    output logic                  phase,
    output logic [PRESCALE_W-1:0] cnt
);
    logic [PRESCALE_W-1:0] cnt_q, cnt_d;
    logic                  phase_q, phase_d;

    // Each half-period lasts load_value + 1 clocks: load_value decrements
    // plus the reload cycle on which the phase flips.
    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (load) begin
            cnt_d   = load_value;
            phase_d = 1'b1;
        end else if (load_value == '0) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - PRESCALE_W'(1);
        end else begin
            cnt_d   = load_value;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign cnt   = cnt_q;
endmodule

// File: rtl/led_pio_out.sv
// rtl/led_pio_out.sv - Avalon-MM output PIO with set/clear/toggle and per-bit blink
//
// Parameters: WIDTH (output bits, 1..32), RESET_VALUE (data after reset),
//             PRESCALE_W (blink period width, 1..32)
// clk      : system clock
// reset_n  : asynchronous active-low reset
// bus      : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
// out_port : driven outputs
// Macro LED_PIO_BLINK_EN builds in the blink engine and registers 4..6;
// without it those addresses are unmapped and out_port follows DATA.
module led_pio_out
    import led_pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 10,
    parameter logic [31:0] RESET_VALUE = 32'h0,
    parameter int unsigned PRESCALE_W  = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    led_pio_out_if.slave     bus,
    output logic [WIDTH-1:0] out_port
);
    logic             wr_en;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             unused_wd;

    assign wr_en     = bus.chipselect && !bus.write_n;
    assign wd        = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;

    always_comb begin
        data_out_d = data_out_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:   data_out_d = wd;
                ADDR_SET:    data_out_d = data_out_q | wd;
                ADDR_CLEAR:  data_out_d = data_out_q & ~wd;
                ADDR_TOGGLE: data_out_d = data_out_q ^ wd;
                default:     data_out_d = data_out_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) data_out_q <= RESET_VALUE[WIDTH-1:0];
        else          data_out_q <= data_out_d;
    end

`ifdef LED_PIO_BLINK_EN
    logic [WIDTH-1:0]      blink_mask_q, blink_mask_d;
    logic [PRESCALE_W-1:0] period_q, period_d;
    logic                  period_wr;
    logic                  phase;
    logic [PRESCALE_W-1:0] cnt;
    logic                  unused_cnt;

    always_comb begin
        blink_mask_d = blink_mask_q;
        period_d     = period_q;
        period_wr    = 1'b0;
        if (wr_en && bus.address == ADDR_BLINK_MASK) begin
            blink_mask_d = wd;
        end
        if (wr_en && bus.address == ADDR_BLINK_PERIOD) begin
            period_d  = bus.writedata[PRESCALE_W-1:0];
            period_wr = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_mask_q <= '0;
            period_q     <= '0;
        end else begin
            blink_mask_q <= blink_mask_d;
            period_q     <= period_d;
        end
    end

    // period_d carries the freshly written value during a load, so the
    // prescaler never needs its own copy of the period.
    led_pio_blink_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (period_wr),
        .load_value (period_d),
        .phase      (phase),
        .cnt        (cnt)
    );

    assign unused_cnt = ^cnt;
    assign out_port   = data_out_q & (~blink_mask_q | {WIDTH{phase}});
`else
    assign out_port = data_out_q;
`endif

    always_comb begin
        bus.readdata = 32'h0;
        case (bus.address)
            ADDR_DATA, ADDR_SET, ADDR_CLEAR, ADDR_TOGGLE:
                bus.readdata = 32'(data_out_q);
`ifdef LED_PIO_BLINK_EN
            ADDR_BLINK_MASK:   bus.readdata = 32'(blink_mask_q);
            ADDR_BLINK_PERIOD: bus.readdata = 32'(period_q);
            ADDR_STATUS:       bus.readdata[STATUS_PHASE_BIT] = phase;
`endif
            default:           bus.readdata = 32'h0;
        endcase
    end
endmodule

// File: tb/tb_led_pio_out.sv
// tb/tb_led_pio_out.sv - self-checking bench for led_pio_out
module tb_led_pio_out;
    localparam int          W  = 10;
    localparam int          PW = 24;
    localparam logic [31:0] RV = 32'h155;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] out_port;

    led_pio_out_if bus();

    led_pio_out #(.WIDTH(W), .RESET_VALUE(RV), .PRESCALE_W(PW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .bus      (bus),
        .out_port (out_port)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: register contents plus the edge index of the last period write;
    // the phase is derived from elapsed edges rather than a counter.
    logic [W-1:0] m_data   = RV[W-1:0];
    logic [W-1:0] m_mask   = '0;
    int           m_period = 0;
    int           m_t0     = 0;
    int           edge_n   = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_data   <= RV[W-1:0];
            m_mask   <= '0;
            m_period <= 0;
            m_t0     <= 0;
        end else begin
            edge_n <= edge_n + 1;
            if (bus.chipselect && !bus.write_n) begin
                case (bus.address)
                    3'd0: m_data <= bus.writedata[W-1:0];
                    3'd1: m_data <= m_data | bus.writedata[W-1:0];
                    3'd2: m_data <= m_data & ~bus.writedata[W-1:0];
                    3'd3: m_data <= m_data ^ bus.writedata[W-1:0];
`ifdef LED_PIO_BLINK_EN
                    3'd4: m_mask <= bus.writedata[W-1:0];
                    3'd5: begin
                        m_period <= int'(bus.writedata[PW-1:0]);
                        m_t0     <= edge_n + 1;
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    function automatic logic exp_phase();
        if (m_period == 0) return 1'b1;
        return (((edge_n - m_t0) / (m_period + 1)) % 2) == 0;
    endfunction

    function automatic logic [W-1:0] exp_out();
        return m_data & (~m_mask | {W{exp_phase()}});
    endfunction

    function automatic logic [31:0] exp_read(input logic [2:0] a);
        case (a)
            3'd0, 3'd1, 3'd2, 3'd3: return 32'(m_data);
`ifdef LED_PIO_BLINK_EN
            3'd4: return 32'(m_mask);
            3'd5: return 32'(m_period);
            3'd6: return {31'h0, exp_phase()};
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        chk("out_port_model", 32'(out_port), 32'(exp_out()));
        chk("readdata_model", bus.readdata, exp_read(bus.address));
    end

    task automatic drive(input logic [2:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp);
        bus.address    = a;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b1;
        #1;
        chk(name, bus.readdata, exp);
    endtask

    initial begin
        bus.address    = 3'd0;
        bus.writedata  = 32'h0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;

        // 1. reset state
        #12;
        chk("reset_out", 32'(out_port), 32'h155);
        rd("reset_data_rd", 3'd0, 32'h155);
        @(posedge clk); #1;
        reset_n = 1'b1;
        idle(2);
        chk("post_reset_out", 32'(out_port), 32'h155);
`ifdef LED_PIO_BLINK_EN
        rd("reset_status", 3'd6, 32'h1);
`endif

        // 2. atomic writes back to back
        drive(3'd0, 32'h3F0); chk("data_3f0",  32'(out_port), 32'h3F0);
        drive(3'd1, 32'h00F); chk("set_3ff",   32'(out_port), 32'h3FF);
        drive(3'd2, 32'h300); chk("clear_0ff", 32'(out_port), 32'h0FF);
        drive(3'd3, 32'h0F0); chk("toggle_00f", 32'(out_port), 32'h00F);
        drive(3'd1, 32'hFFFF_FC00); chk("set_upper_ignored", 32'(out_port), 32'h00F);
        idle(1);
        rd("data_rd_00f", 3'd2, 32'h00F);

`ifdef LED_PIO_BLINK_EN
        // 3. blink bit 0 with period 3
        drive(3'd0, 32'h3FF);
        drive(3'd4, 32'h001);
        drive(3'd5, 32'd3);
        for (int i = 0; i < 16; i++) begin
            chk("blink_p3", 32'(out_port), ((i / 4) % 2 == 0) ? 32'h3FF : 32'h3FE);
            rd("status_p3", 3'd6, ((i / 4) % 2 == 0) ? 32'h1 : 32'h0);
            idle(1);
        end
        idle(4);
        chk("blink_off_phase", 32'(out_port), 32'h3FE);

        // 4. reload while off, then stop
        drive(3'd5, 32'd1);
        for (int i = 0; i < 8; i++) begin
            chk("blink_p1", 32'(out_port), ((i / 2) % 2 == 0) ? 32'h3FF : 32'h3FE);
            idle(1);
        end
        drive(3'd5, 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("blink_stop", 32'(out_port), 32'h3FF);
            idle(1);
        end
        rd("mask_rd", 3'd4, 32'h001);
        drive(3'd6, 32'h0);
        rd("status_ro", 3'd6, 32'h1);

        // 5. asynchronous reset mid-blink
        drive(3'd5, 32'd2);
        idle(3);
        chk("pre_reset_off", 32'(out_port), 32'h3FE);
        reset_n = 1'b0;
        #1;
        chk("async_reset_out", 32'(out_port), 32'h155);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("idle_after_reset", 32'(out_port), 32'h155);
            idle(1);
        end
        rd("period_after_reset", 3'd5, 32'h0);
        rd("status_after_reset", 3'd6, 32'h1);
`else
        // 6b. addresses 4..6 unmapped without the blink engine
        drive(3'd4, 32'hFFFF_FFFF);
        drive(3'd5, 32'hFFFF_FFFF);
        drive(3'd6, 32'hFFFF_FFFF);
        idle(3);
        chk("unmapped_4_6_out", 32'(out_port), 32'h00F);
        rd("rd4_zero", 3'd4, 32'h0);
        rd("rd5_zero", 3'd5, 32'h0);
        rd("rd6_zero", 3'd6, 32'h0);
        idle(1);
`endif

        // 6. address 7 unmapped
        drive(3'd0, 32'h2A5);
        drive(3'd7, 32'hFFFF_FFFF);
        chk("addr7_out", 32'(out_port), 32'h2A5);
        rd("rd7_zero", 3'd7, 32'h0);
        idle(3);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
